// File: rtl/mfp_irq_ctrl_if.sv
// mfp_irq_ctrl_if: CPU-side register bus and interrupt-acknowledge handshake
// for mfp_irq_ctrl. The CPU is the master, the controller the slave.
interface mfp_irq_ctrl_if;
   logic       REG_WE;
   logic [3:0] REG_SEL;
   logic [7:0] DAT_I;
   logic [7:0] DAT_O;
   logic       IACK;
   logic [7:0] VEC_O;
   logic       VEC_VALID;
   logic       VEC_NONE;

   modport master (
      output REG_WE, REG_SEL, DAT_I, IACK,
      input  DAT_O, VEC_O, VEC_VALID, VEC_NONE
   );

   modport slave (
      input  REG_WE, REG_SEL, DAT_I, IACK,
      output DAT_O, VEC_O, VEC_VALID, VEC_NONE
   );
endinterface

// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: 16-channel MFP68901-style interrupt controller with vectored acknowledge.
// Defining MFP_IRQ_DAISY_EN adds the IEI_N/IEO_N daisy-chain ports.
module mfp_irq_ctrl #(
   parameter int         SYNC_IN  = 0,
   parameter logic [7:0] VR_RESET = 8'h00
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [15:0]   IRQ_I,
   output logic          INT_N,
`ifdef MFP_IRQ_DAISY_EN
   input  logic          IEI_N,
   output logic          IEO_N,
`endif
   mfp_irq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ARB, VEC} state_e;

   state_e      state_q, state_d;
   logic [15:0] ier_q, ier_d, ipr_q, ipr_d, isr_q, isr_d, imr_q, imr_d;
   logic [7:0]  vr_q, vr_d, vec_q, vec_d;
   logic [15:0] irq_prev_q;
   logic        int_n_q, int_n_d;
   logic        vec_valid_q, vec_valid_d, vec_none_q, vec_none_d;
   logic [15:0] irq_s, isr_above, elig;
   logic [3:0]  top_ch;
   logic        iei_n;

   generate
      if (SYNC_IN != 0) begin : g_sync
         logic [15:0] sync1_q, sync2_q;
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               sync1_q <= '0;
               sync2_q <= '0;
            end else begin
               sync1_q <= IRQ_I;
               sync2_q <= sync1_q;
            end
         end
         assign irq_s = sync2_q;
      end else begin : g_nosync
         assign irq_s = IRQ_I;
      end
   endgenerate

`ifdef MFP_IRQ_DAISY_EN
   logic ieo_n_q, ieo_n_d;
   assign iei_n = IEI_N;
   assign IEO_N = ieo_n_q;
`else
   assign iei_n = 1'b0;
`endif

   // A channel is eligible only above the highest channel currently in service.
   always_comb begin
      isr_above = '0;
      for (int n = 0; n < 16; n++) begin
         isr_above[n] = ((isr_q >> n) == 16'd0);
      end
      elig   = ipr_q & imr_q & isr_above;
      top_ch = '0;
      for (int n = 0; n < 16; n++) begin
         if (elig[n]) top_ch = 4'(n);
      end
   end

   always_comb begin
      ier_d       = ier_q;
      ipr_d       = ipr_q;
      isr_d       = isr_q;
      imr_d       = imr_q;
      vr_d        = vr_q;
      vec_d       = vec_q;
      state_d     = state_q;
      vec_valid_d = vec_valid_q;
      vec_none_d  = vec_none_q;
`ifdef MFP_IRQ_DAISY_EN
      ieo_n_d     = ieo_n_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.IACK && !iei_n) state_d = ARB;
         end
         ARB: begin
            state_d = VEC;
            if (|elig) begin
               vec_d         = {vr_q[7:4], top_ch};
               ipr_d[top_ch] = 1'b0;
               if (vr_q[3]) isr_d[top_ch] = 1'b1;
               vec_valid_d   = 1'b1;
            end else begin
`ifdef MFP_IRQ_DAISY_EN
               ieo_n_d    = 1'b0;
`else
               vec_none_d = 1'b1;
`endif
            end
         end
         VEC: begin
            if (!bus.IACK) begin
               state_d     = IDLE;
               vec_valid_d = 1'b0;
               vec_none_d  = 1'b0;
`ifdef MFP_IRQ_DAISY_EN
               ieo_n_d     = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // CPU writes land after the acknowledge capture; event sets win over every clear.
      if (bus.REG_WE) begin
         case (bus.REG_SEL)
            4'd0: begin
               ier_d[15:8] = bus.DAT_I;
               ipr_d[15:8] = ipr_d[15:8] & bus.DAT_I;
            end
            4'd1: begin
               ier_d[7:0] = bus.DAT_I;
               ipr_d[7:0] = ipr_d[7:0] & bus.DAT_I;
            end
            4'd2: ipr_d[15:8] = ipr_d[15:8] & bus.DAT_I;
            4'd3: ipr_d[7:0]  = ipr_d[7:0] & bus.DAT_I;
            4'd4: isr_d[15:8] = isr_d[15:8] & bus.DAT_I;
            4'd5: isr_d[7:0]  = isr_d[7:0] & bus.DAT_I;
            4'd6: imr_d[15:8] = bus.DAT_I;
            4'd7: imr_d[7:0]  = bus.DAT_I;
            4'd8: vr_d        = bus.DAT_I;
            default: ;
         endcase
      end
      ipr_d = ipr_d | (irq_s & ~irq_prev_q & ier_q);

      int_n_d = 1'b1;
      if ((state_d == IDLE) && !(bus.IACK && iei_n)) int_n_d = ~(|elig);
   end

   always_comb begin
      bus.DAT_O = 8'h00;
      case (bus.REG_SEL)
         4'd0: bus.DAT_O = ier_q[15:8];
         4'd1: bus.DAT_O = ier_q[7:0];
         4'd2: bus.DAT_O = ipr_q[15:8];
         4'd3: bus.DAT_O = ipr_q[7:0];
         4'd4: bus.DAT_O = isr_q[15:8];
         4'd5: bus.DAT_O = isr_q[7:0];
         4'd6: bus.DAT_O = imr_q[15:8];
         4'd7: bus.DAT_O = imr_q[7:0];
         4'd8: bus.DAT_O = vr_q;
         default: bus.DAT_O = 8'h00;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         ier_q       <= '0;
         ipr_q       <= '0;
         isr_q       <= '0;
         imr_q       <= '0;
         vr_q        <= VR_RESET;
         vec_q       <= '0;
         irq_prev_q  <= '0;
         int_n_q     <= 1'b1;
         vec_valid_q <= 1'b0;
         vec_none_q  <= 1'b0;
`ifdef MFP_IRQ_DAISY_EN
         ieo_n_q     <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         ier_q       <= ier_d;
         ipr_q       <= ipr_d;
         isr_q       <= isr_d;
         imr_q       <= imr_d;
         vr_q        <= vr_d;
         vec_q       <= vec_d;
         irq_prev_q  <= irq_s;
         int_n_q     <= int_n_d;
         vec_valid_q <= vec_valid_d;
         vec_none_q  <= vec_none_d;
`ifdef MFP_IRQ_DAISY_EN
         ieo_n_q     <= ieo_n_d;
`endif
      end
   end

   assign INT_N         = int_n_q;
   assign bus.VEC_O     = vec_q;
   assign bus.VEC_VALID = vec_valid_q;
   assign bus.VEC_NONE  = vec_none_q;

endmodule
